// File: rtl/usb_pkg.sv
// usb_pkg: PID codes, pidSel encoding and FSM states shared by the handshake transmitter
package usb_pkg;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;
    localparam logic [7:0] PID_NYET  = 8'h96;

    typedef enum logic [1:0] {SEL_ACK, SEL_NAK, SEL_STALL, SEL_NYET} pid_sel_t;

    typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_PID, ST_EOP, ST_JBIT, ST_GAP} state_t;

    function automatic logic [7:0] pid_byte(input logic [1:0] sel);
        return sel == SEL_ACK   ? PID_ACK   :
               sel == SEL_NAK   ? PID_NAK   :
               sel == SEL_STALL ? PID_STALL : PID_NYET;
    endfunction
endpackage

// File: rtl/usb_nrzi_enc.sv
// usb_nrzi_enc: NRZI line-level register (raw 0 toggles, raw 1 holds)
// Ports:
//   clk, rst_n  - clock, async active-low reset (level resets to 1 = J)
//   i_strobe    - bit strobe; the level only moves on strobe cycles
//   i_enc_en    - encode the current raw bit into the level
//   i_load_j    - force the level back to J (1)
//   i_raw       - raw bit being presented
//   o_level     - level that results from encoding i_raw (becomes the line level)
module usb_nrzi_enc (
    input  logic clk,
    input  logic rst_n,
    input  logic i_strobe,
    input  logic i_enc_en,
    input  logic i_load_j,
    input  logic i_raw,
    output logic o_level
);
    logic r_level;

    assign o_level = i_raw ? r_level : ~r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_level <= 1'b1;
        else if (i_strobe && i_load_j)
            r_level <= 1'b1;
        else if (i_strobe && i_enc_en)
            r_level <= o_level;
    end
endmodule

// File: rtl/usb_handshake_tx.sv
// usb_handshake_tx: bit-serial USB handshake transmitter (SYNC, PID, EOP, J) with one-deep request queue
// Ports:
//   useClk, resetN - clock, async active-low reset
//   checkData      - bit strobe; all bit-level state moves only when high
//   req, pidSel    - handshake request and PID select (ACK/NAK/STALL/NYET)
//   reqReady       - a request presented this cycle is taken
//   txData, txOE   - serial data / line level and output enable
//   callEop        - SE0 request to the line driver
//   busy, done     - activity flag and end-of-J-bit pulse
module usb_handshake_tx
    import usb_pkg::*;
#(
    parameter int SYNC_LEN = 8,
    parameter int EOP_BITS = 2,
    parameter int GAP_BITS = 2,
    parameter int NRZI_EN  = 0
) (
    input  logic       useClk,
    input  logic       resetN,
    input  logic       checkData,
    input  logic       req,
    input  logic [1:0] pidSel,
    output logic       reqReady,
    output logic       txData,
    output logic       txOE,
    output logic       callEop,
    output logic       busy,
    output logic       done
);
    state_t     r_state, w_nxt_state;
    logic [4:0] r_cnt, w_nxt_cnt;
    logic       r_act_v, r_pend_v;
    logic [7:0] r_act_pid, r_pend_pid;
    logic       r_tx_data, r_oe, r_eop, r_done;
    logic       w_raw, w_enc, w_lvl, w_nxt_data;
    logic       w_to_idle, w_pkt_end, w_acc_act;

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            ST_IDLE: w_nxt_state = r_act_v ? ST_SYNC : ST_IDLE;
            ST_SYNC: w_nxt_state = r_cnt == 5'(SYNC_LEN - 1) ? ST_PID : ST_SYNC;
            ST_PID:  w_nxt_state = r_cnt == 5'd7 ? ST_EOP : ST_PID;
            ST_EOP:  w_nxt_state = r_cnt == 5'(EOP_BITS - 1) ? ST_JBIT : ST_EOP;
            ST_JBIT: w_nxt_state = GAP_BITS > 0 ? ST_GAP : ST_IDLE;
            ST_GAP:  w_nxt_state = r_cnt == 5'(GAP_BITS - 1) ? ST_IDLE : ST_GAP;
            default: w_nxt_state = ST_IDLE;
        endcase
        w_nxt_cnt = (w_nxt_state != r_state || r_state == ST_IDLE) ? 5'd0 : r_cnt + 5'd1;
        w_enc = w_nxt_state == ST_SYNC || w_nxt_state == ST_PID;
        // raw bit to present on this strobe; idle and gap simply hold the line value
        w_raw = w_nxt_state == ST_SYNC ? (w_nxt_cnt == 5'(SYNC_LEN - 1)) :
                w_nxt_state == ST_PID  ? r_act_pid[w_nxt_cnt[2:0]] :
                w_nxt_state == ST_EOP  ? 1'b0 :
                w_nxt_state == ST_JBIT ? 1'b1 : r_tx_data;
    end

    assign w_nxt_data = (w_enc && NRZI_EN != 0) ? w_lvl : w_raw;

    usb_nrzi_enc u_nrzi (
        .clk      (useClk),
        .rst_n    (resetN),
        .i_strobe (checkData),
        .i_enc_en (w_enc && NRZI_EN != 0),
        .i_load_j (w_nxt_state == ST_JBIT),
        .i_raw    (w_raw),
        .o_level  (w_lvl)
    );

    always_ff @(posedge useClk or negedge resetN) begin
        if (!resetN) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_tx_data <= NRZI_EN != 0;
            r_oe      <= 1'b0;
            r_eop     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= checkData && r_state == ST_JBIT;
            if (checkData) begin
                r_state   <= w_nxt_state;
                r_cnt     <= w_nxt_cnt;
                r_tx_data <= w_nxt_data;
                r_oe      <= w_nxt_state inside {ST_SYNC, ST_PID, ST_EOP, ST_JBIT};
                r_eop     <= w_nxt_state == ST_EOP;
            end
        end
    end

    assign w_to_idle = checkData && r_state != ST_IDLE && w_nxt_state == ST_IDLE;
    assign w_pkt_end = checkData && r_state == ST_JBIT;
    assign w_acc_act = req && r_state == ST_IDLE && !r_act_v;

    // On the return to IDLE the pending slot promotes to active; if it is empty,
    // a request arriving on that very clock goes straight into the active slot.
    always_ff @(posedge useClk or negedge resetN) begin
        if (!resetN) begin
            r_act_v    <= 1'b0;
            r_act_pid  <= '0;
            r_pend_v   <= 1'b0;
            r_pend_pid <= '0;
        end else if (w_to_idle) begin
            r_act_v   <= r_pend_v || req;
            r_act_pid <= r_pend_v ? r_pend_pid : pid_byte(pidSel);
            r_pend_v  <= 1'b0;
        end else begin
            if (w_pkt_end)
                r_act_v <= 1'b0;
            else if (w_acc_act) begin
                r_act_v   <= 1'b1;
                r_act_pid <= pid_byte(pidSel);
            end
            if (req && !r_pend_v && !w_acc_act) begin
                r_pend_v   <= 1'b1;
                r_pend_pid <= pid_byte(pidSel);
            end
        end
    end

    assign reqReady = !r_pend_v;
    assign txData   = r_tx_data;
    assign txOE     = r_oe;
    assign callEop  = r_eop;
    assign done     = r_done;
    assign busy     = r_state != ST_IDLE || r_act_v || r_pend_v;
endmodule

// File: tb/tb_usb_handshake_tx.sv
// tb_usb_handshake_tx: directed checks of the handshake transmitter (raw and NRZI instances)
module tb_usb_handshake_tx;
    logic       useClk = 1'b0, resetN = 1'b0, checkData = 1'b0, req = 1'b0;
    logic [1:0] pidSel = 2'd0;
    logic       reqReady, txData, txOE, callEop, busy, done;
    logic       reqReady_n, txData_n, txOE_n, callEop_n, busy_n, done_n;

    int errors = 0, checks = 0;
    int stb_div = 1, cyc = 0, ncyc = 0;
    logic stb_q = 1'b0, oe_prev = 1'b0;
    logic [63:0] cap_d = '0, cap_e = '0, cap_n = '0;
    int oe_cnt = 0, oe_clk = 0, done_cnt = 0, done_cnt_n = 0, t_done = 0, t_rise = 0;
    int b_oe, b_clk, b_done, b_dn, td;
    logic hit;

    usb_handshake_tx dut (
        .useClk(useClk), .resetN(resetN), .checkData(checkData), .req(req), .pidSel(pidSel),
        .reqReady(reqReady), .txData(txData), .txOE(txOE), .callEop(callEop), .busy(busy), .done(done)
    );

    usb_handshake_tx #(.NRZI_EN(1)) dut_n (
        .useClk(useClk), .resetN(resetN), .checkData(checkData), .req(req), .pidSel(pidSel),
        .reqReady(reqReady_n), .txData(txData_n), .txOE(txOE_n), .callEop(callEop_n), .busy(busy_n), .done(done_n)
    );

    always #5 useClk = ~useClk;

    initial forever begin
        @(posedge useClk);
        #1;
        checkData = (cyc % stb_div) == 0;
        cyc++;
    end

    always @(posedge useClk) stb_q <= checkData;

    // one captured bit per strobe while txOE is high
    always @(negedge useClk) begin
        ncyc++;
        if (stb_q && txOE) begin
            cap_d = {cap_d[62:0], txData};
            cap_e = {cap_e[62:0], callEop};
            oe_cnt++;
        end
        if (stb_q && txOE_n) cap_n = {cap_n[62:0], txData_n};
        if (txOE) oe_clk++;
        if (txOE && !oe_prev) t_rise = ncyc;
        oe_prev = txOE;
        if (done) begin
            done_cnt++;
            t_done = ncyc;
        end
        if (done_n) done_cnt_n++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge useClk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel);
        req = 1'b1;
        pidSel = sel;
        tick(1);
        req = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_cnt < n && k < budget) begin
            tick(1);
            k++;
        end
        chk("done_timeout", 64'(done_cnt >= n), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1);
    end

    initial begin
        tick(2);
        chk("rst_txOE", 64'(txOE), 64'd0);
        chk("rst_callEop", 64'(callEop), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_reqReady", 64'(reqReady), 64'd1);
        chk("rst_txData_raw", 64'(txData), 64'd0);
        chk("rst_txData_nrzi", 64'(txData_n), 64'd1);
        resetN = 1'b1;
        tick(2);

        // ACK at defaults
        b_oe = oe_cnt; b_done = done_cnt;
        send(2'd0);
        wait_done(b_done + 1, 100);
        tick(6);
        chk("ack_data", 64'(cap_d[18:0]), 64'b0000000_1_01001011_00_1);
        chk("ack_eop", 64'(cap_e[18:0]), 64'b0000000_0_00000000_11_0);
        chk("ack_oe_strobes", 64'(oe_cnt - b_oe), 64'd19);
        chk("ack_done_pulses", 64'(done_cnt - b_done), 64'd1);
        chk("ack_idle", 64'({busy, txOE}), 64'd0);

        // NAK, checked on both the raw and the NRZI instance
        b_done = done_cnt; b_dn = done_cnt_n;
        send(2'd1);
        wait_done(b_done + 1, 100);
        tick(6);
        chk("nak_raw", 64'(cap_d[18:0]), 64'b0000000_1_01011010_00_1);
        chk("nak_nrzi", 64'(cap_n[18:0]), 64'b0101010_0_11000110_00_1);
        chk("nak_nrzi_done", 64'(done_cnt_n - b_dn), 64'd1);

        // back-to-back ACK then STALL, third request ignored
        b_oe = oe_cnt; b_done = done_cnt;
        send(2'd0);
        tick(3);
        send(2'd2);
        chk("b2b_ready_low", 64'(reqReady), 64'd0);
        send(2'd3);
        chk("b2b_full_ready_low", 64'(reqReady), 64'd0);
        wait_done(b_done + 1, 100);
        td = t_done;
        wait_done(b_done + 2, 100);
        tick(10);
        chk("b2b_data", 64'(cap_d[37:0]), 64'b0000000_1_01001011_00_1_0000000_1_01111000_00_1);
        chk("b2b_oe_strobes", 64'(oe_cnt - b_oe), 64'd38);
        chk("b2b_done_pulses", 64'(done_cnt - b_done), 64'd2);
        chk("b2b_gap_clocks", 64'(t_rise - td), 64'd3);
        chk("b2b_ready_back", 64'(reqReady), 64'd1);

        // strobe every 4th clock; request taken during the gap
        stb_div = 4;
        b_oe = oe_cnt; b_clk = oe_clk; b_done = done_cnt;
        send(2'd0);
        wait_done(b_done + 1, 400);
        tick(1);
        chk("slow_gap_ready", 64'(reqReady), 64'd1);
        send(2'd1);
        chk("slow_gap_accepted", 64'(reqReady), 64'd0);
        wait_done(b_done + 2, 400);
        tick(40);
        chk("slow_data", 64'(cap_d[37:0]), 64'b0000000_1_01001011_00_1_0000000_1_01011010_00_1);
        chk("slow_oe_strobes", 64'(oe_cnt - b_oe), 64'd38);
        chk("slow_oe_clocks", 64'(oe_clk - b_clk), 64'd152);

        // reset in the middle of PID bit 3, then a full NYET
        stb_div = 1;
        tick(8);
        b_oe = oe_cnt; b_done = done_cnt;
        send(2'd3);
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge useClk);
            #1;
            hit = (oe_cnt - b_oe) == 12;
        end
        chk("rst_reach_pid3", 64'(hit), 64'd1);
        resetN = 1'b0;
        #1;
        chk("abort_txOE", 64'(txOE), 64'd0);
        chk("abort_callEop", 64'(callEop), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_reqReady", 64'(reqReady), 64'd1);
        chk("abort_no_done", 64'(done_cnt - b_done), 64'd0);
        tick(1);
        resetN = 1'b1;
        tick(2);
        b_oe = oe_cnt; b_done = done_cnt;
        send(2'd3);
        wait_done(b_done + 1, 100);
        tick(6);
        chk("nyet_data", 64'(cap_d[18:0]), 64'b0000000_1_01101001_00_1);
        chk("nyet_eop", 64'(cap_e[18:0]), 64'b0000000_0_00000000_11_0);
        chk("nyet_oe_strobes", 64'(oe_cnt - b_oe), 64'd19);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
